// File: rtl/cpu_oci_trace_pkg.sv
// Shared types and constants for the OCI trace capture block: FSM encoding,
// default sizes and a constant-friendly clog2 helper.
package cpu_oci_trace_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } trace_state_e;

  localparam int DEF_DCT_W  = 30;
  localparam int DEF_CNT_W  = 4;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_DROP_W = 16;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cpu_oci_trace_fifo.sv
// First-word-fall-through FIFO; the head entry is always visible on rdata.
// Full/empty come from the occupancy count, so pointers need no extra wrap bit.
module cpu_oci_trace_fifo
  import cpu_oci_trace_pkg::*;
#(
  parameter int W     = 34,
  parameter int DEPTH = DEF_DEPTH,
  localparam int PTR_W = clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset: contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/cpu_oci_trace_capture.sv
// Trace capture beside the CPU OCI: buffers {dct_count, dct_buffer} words and
// sequences end-of-test as RUN -> FLUSH -> DONE while the consumer drains.
module cpu_oci_trace_capture
  import cpu_oci_trace_pkg::*;
#(
  parameter int DCT_W  = DEF_DCT_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DROP_W = DEF_DROP_W,
  localparam int LVL_W = clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [DCT_W-1:0]       dct_buffer,
  input  logic [CNT_W-1:0]       dct_count,
  input  logic                   dct_valid,
  input  logic                   test_ending,
  input  logic                   test_has_ended,
  output logic                   rd_valid,
  output logic [CNT_W+DCT_W-1:0] rd_data,
  input  logic                   rd_ready,
  output logic [LVL_W-1:0]       level,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_cnt,
  output logic                   capturing,
  output logic                   done,
  output logic [1:0]             dbg_state
);

  // Readout handshake: a word moves on every rising edge where rd_valid and
  // rd_ready are both 1; while rd_valid=1 and rd_ready=0, rd_data holds steady.
  trace_state_e state;
  logic         ended_seen;
  logic         fifo_full;
  logic         fifo_empty;
  logic         pop;
  logic         push;
  logic         drop;
  logic         in_run;

  assign in_run    = (state == ST_RUN);
  assign rd_valid  = !fifo_empty;
  assign pop       = rd_valid && rd_ready;
  assign push      = in_run && dct_valid && (!fifo_full || pop);
  assign drop      = in_run && dct_valid && fifo_full && !pop;
  assign dbg_state = state;

  cpu_oci_trace_fifo #(
    .W     (CNT_W + DCT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   ({dct_count, dct_buffer}),
    .rdata   (rd_data),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_RUN;
      ended_seen <= 1'b0;
      overflow   <= 1'b0;
      drop_cnt   <= '0;
      capturing  <= 1'b1;
      done       <= 1'b0;
    end else begin
      if (test_has_ended) ended_seen <= 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
      end
      // DONE waits for both an empty FIFO and a seen test_has_ended.
      case (state)
        ST_RUN: begin
          if (test_ending || test_has_ended) begin
            state     <= ST_FLUSH;
            capturing <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (fifo_empty && ended_seen) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: state <= ST_DONE;
        default: begin
          state     <= ST_DONE;
          capturing <= 1'b0;
          done      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_oci_trace_capture.sv
// Bench for cpu_oci_trace_capture: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_cpu_oci_trace_capture;

  localparam int DCT_W  = 30;
  localparam int CNT_W  = 4;
  localparam int DEPTH  = 4;
  localparam int DROP_W = 4;
  localparam int DW     = CNT_W + DCT_W;
  localparam int LVL_W  = 3;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic              clk;
  logic              reset_n;
  logic [DCT_W-1:0]  dct_buffer;
  logic [CNT_W-1:0]  dct_count;
  logic              dct_valid;
  logic              test_ending;
  logic              test_has_ended;
  logic              rd_valid;
  logic [DW-1:0]     rd_data;
  logic              rd_ready;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;
  logic              capturing;
  logic              done;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  cpu_oci_trace_capture #(
    .DCT_W (DCT_W), .CNT_W (CNT_W), .DEPTH (DEPTH), .DROP_W (DROP_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .dct_valid      (dct_valid),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .rd_ready       (rd_ready),
    .level          (level),
    .overflow       (overflow),
    .drop_cnt       (drop_cnt),
    .capturing      (capturing),
    .done           (done),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [DW-1:0] exp_q[$];
  int            m_state;   // 0 = RUN, 1 = FLUSH, 2 = DONE
  bit            m_ended;
  bit            m_ovf;
  int            m_drop;

  always @(posedge clk or negedge reset_n) begin
    bit pop_now;
    int sz;
    if (!reset_n) begin
      exp_q.delete();
      m_state = 0;
      m_ended = 1'b0;
      m_ovf   = 1'b0;
      m_drop  = 0;
    end else begin
      sz      = exp_q.size();
      pop_now = (sz > 0) && rd_ready;
      if (pop_now) void'(exp_q.pop_front());
      if (m_state == 0 && dct_valid) begin
        if (sz < DEPTH || pop_now) exp_q.push_back({dct_count, dct_buffer});
        else begin
          m_ovf = 1'b1;
          if (m_drop < DROP_MAX) m_drop = m_drop + 1;
        end
      end
      if (m_state == 0 && (test_ending || test_has_ended)) m_state = 1;
      else if (m_state == 1 && sz == 0 && m_ended) m_state = 2;
      if (test_has_ended) m_ended = 1'b1;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      chk("rd_valid", 64'(rd_valid), 64'(exp_q.size() != 0));
      chk("level", 64'(level), 64'(exp_q.size()));
      if (exp_q.size() != 0) chk("rd_data", 64'(rd_data), 64'(exp_q[0]));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
      chk("capturing", 64'(capturing), 64'(m_state == 0));
      chk("done", 64'(done), 64'(m_state == 2));
      chk("dbg_state", 64'(dbg_state), 64'(m_state));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit v, input logic [DCT_W-1:0] b, input logic [CNT_W-1:0] c,
                     input bit rdy, input bit te, input bit th);
    dct_valid      = v;
    dct_buffer     = b;
    dct_count      = c;
    rd_ready       = rdy;
    test_ending    = te;
    test_has_ended = th;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    dct_valid = 1'b0; rd_ready = 1'b0; test_ending = 1'b0; test_has_ended = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    dct_buffer = '0; dct_count = '0;
    do_reset();
    chk("reset_level", 64'(level), 64'(0));
    chk("reset_rd_valid", 64'(rd_valid), 64'(0));
    chk("reset_capturing", 64'(capturing), 64'(1));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_drop", 64'(drop_cnt), 64'(0));

    // Basic streaming with rd_ready held high
    cyc(1, 30'h1, 4'h1, 1, 0, 0);
    chk("basic_w1", 64'(rd_data), 64'({4'h1, 30'h1}));
    cyc(1, 30'h2, 4'h2, 1, 0, 0);
    chk("basic_w2", 64'(rd_data), 64'({4'h2, 30'h2}));
    cyc(1, 30'h3, 4'h3, 1, 0, 0);
    chk("basic_w3", 64'(rd_data), 64'({4'h3, 30'h3}));
    cyc(0, '0, '0, 1, 0, 0);
    chk("basic_level0", 64'(level), 64'(0));

    // Overflow, then full with simultaneous push/pop, then drain
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1, 30'(32'h10 + i), 4'(i), 0, 0, 0);
    chk("ovf_level", 64'(level), 64'(4));
    chk("ovf_flag", 64'(overflow), 64'(1));
    chk("ovf_drop", 64'(drop_cnt), 64'(2));
    chk("ovf_head", 64'(rd_data), 64'({4'h0, 30'h10}));
    cyc(1, 30'h99, 4'h9, 1, 0, 0);
    chk("full_pp_level", 64'(level), 64'(4));
    chk("full_pp_drop", 64'(drop_cnt), 64'(2));
    for (int k = 1; k < 4; k++) begin
      chk("drain_word", 64'(rd_data), 64'({4'(k), 30'(32'h10 + k)}));
      cyc(0, '0, '0, 1, 0, 0);
    end
    chk("drain_last", 64'(rd_data), 64'({4'h9, 30'h99}));
    cyc(0, '0, '0, 1, 0, 0);
    chk("drain_level", 64'(level), 64'(0));

    // End sequence
    do_reset();
    cyc(1, 30'h21, 4'h1, 0, 0, 0);
    cyc(1, 30'h22, 4'h2, 0, 0, 0);
    cyc(0, '0, '0, 0, 1, 0);
    chk("end_capturing", 64'(capturing), 64'(0));
    cyc(1, 30'h23, 4'h3, 0, 0, 0);
    chk("end_ignored_level", 64'(level), 64'(2));
    chk("end_ignored_drop", 64'(drop_cnt), 64'(0));
    cyc(0, '0, '0, 0, 0, 1);
    chk("end_not_done", 64'(done), 64'(0));
    cyc(0, '0, '0, 1, 0, 0);
    chk("end_second", 64'(rd_data), 64'({4'h2, 30'h22}));
    cyc(0, '0, '0, 1, 0, 0);
    chk("end_done_wait", 64'(done), 64'(0));
    cyc(0, '0, '0, 0, 0, 0);
    chk("end_done", 64'(done), 64'(1));

    // test_ending + test_has_ended together while empty
    do_reset();
    cyc(0, '0, '0, 0, 1, 1);
    chk("both_flush", 64'(dbg_state), 64'(1));
    cyc(0, '0, '0, 0, 0, 0);
    chk("both_done", 64'(done), 64'(1));

    // dct_valid together with test_ending: word is still captured
    do_reset();
    cyc(1, 30'h31, 4'h1, 0, 1, 0);
    chk("valid_te_level", 64'(level), 64'(1));
    chk("valid_te_capt", 64'(capturing), 64'(0));

    // Pointer wrap and asynchronous reset mid-operation
    do_reset();
    cyc(1, 30'h40, 4'h0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) cyc(1, 30'(32'h40 + i), 4'(i), 1, 0, 0);
    chk("wrap_head", 64'(rd_data), 64'({4'hA, 30'h4A}));
    cyc(1, 30'h50, 4'h0, 0, 0, 0);
    cyc(1, 30'h51, 4'h1, 0, 0, 0);
    chk("wrap_level3", 64'(level), 64'(3));
    reset_n = 1'b0;
    #1;
    chk("async_level", 64'(level), 64'(0));
    chk("async_rd_valid", 64'(rd_valid), 64'(0));
    chk("async_state", 64'(dbg_state), 64'(0));
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Random traffic, periodic resets, varying consumer pressure
    for (int ph = 0; ph < 12; ph++) begin
      int vp;
      int rp;
      vp = $urandom_range(30, 95);
      rp = $urandom_range(5, 80);
      do_reset();
      for (int n = 0; n < 200; n++) begin
        cyc($urandom_range(0, 99) < vp, 30'($urandom), 4'($urandom),
            $urandom_range(0, 99) < rp,
            $urandom_range(0, 149) == 0, $urandom_range(0, 119) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
